tia_hmove_controller: RTL and testbench

TIA_HMOVE_CONTROLLER -- requirements
Module: tia_hmove_controller

---
 rtl/tia_hmove_controller.sv | 104 ++++++++++
 tb/tb_tia_hmove_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tia_hmove_controller.sv
// tia_hmove_controller: horizontal-motion (HMOVE) sequencer.
// Holds five 4-bit motion values (P0, P1, M0, M1, BL). After a strobe it runs
// a fixed 64-cycle sequence and emits one extra-clock pulse (active low on
// mec_bar) every 4 cycles per object. Each object receives (hm XOR 8) pulses.
// Optional feature macro: TIA_HMOVE_BLANK_EN. When it is defined, hmove_blank
// is high for the first 8 busy cycles after every strobe.
module tia_hmove_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       hmove_strobe,
  input  logic       hmclr,
  input  logic [4:0] hm_wr,
  input  logic [3:0] hm_data,
  output logic [4:0] mec_bar,
  output logic       hmove_busy,
  output logic       hmove_blank
);

  logic [3:0] r_hm [0:4];
  logic       r_busy;
  logic [3:0] r_cnt;
  logic [1:0] r_ph;
  logic [4:0] r_en;

  logic [4:0] w_step;
  logic [4:0] w_match;
  logic [4:0] w_done;

  // Motion registers: a clear takes priority over any write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (reset || hmclr)
        r_hm[i] <= 4'd0;
      else if (hm_wr[i])
        r_hm[i] <= hm_data;
    end
  end

  // Per-object step decode: this is evaluated once per 4-cycle step, at ph=0.
  // A match with the live motion value stops the pulses for that object.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_obj
      assign w_step[gi]  = r_busy && (r_ph == 2'd0) && r_en[gi];
      assign w_match[gi] = (r_cnt == (r_hm[gi] ^ 4'b0111));
      assign w_done[gi]  = w_step[gi] && w_match[gi];
      assign mec_bar[gi] = ~(w_step[gi] && !w_match[gi]);
    end
  endgenerate

  // Sequencer: a strobe always (re)starts; otherwise step the phase and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= 4'd0;
      r_ph   <= 2'd0;
      r_en   <= 5'b00000;
    end else if (hmove_strobe) begin
      r_busy <= 1'b1;
      r_cnt  <= 4'd15;
      r_ph   <= 2'd0;
      r_en   <= 5'b11111;
    end else if (r_busy) begin
      r_ph <= r_ph + 2'd1;
      r_en <= r_en & ~w_done;
      if (r_ph == 2'd3) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_busy <= 1'b0;
          r_en   <= 5'b00000;
        end
      end
    end
  end

  assign hmove_busy = r_busy;

`ifdef TIA_HMOVE_BLANK_EN
  logic       r_blank;
  logic [2:0] r_bcnt;

  // Blank window: set by each strobe, lasts 8 cycles (counter 7 down to 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= 1'b0;
      r_bcnt  <= 3'd0;
    end else if (hmove_strobe) begin
      r_blank <= 1'b1;
      r_bcnt  <= 3'd7;
    end else if (r_blank) begin
      if (r_bcnt == 3'd0)
        r_blank <= 1'b0;
      else
        r_bcnt <= r_bcnt - 3'd1;
    end
  end

  assign hmove_blank = r_blank;
`else
  assign hmove_blank = 1'b0;
`endif

endmodule

// File: tb/tb_tia_hmove_controller.sv
// Testbench for tia_hmove_controller: the driver applies one input vector per
// clock edge and pushes the expected outputs for the following cycle into a
// queue. A separate monitor pops one entry and compares it on every falling
// edge. The reference model is time based: a strobe at edge N gives object i
// (hm[i] XOR 8) pulses in cycles N+1+4k, busy in N+1..N+64, and blank in N+1..N+8.
module tb_tia_hmove_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       hmove_strobe;
  logic       hmclr;
  logic [4:0] hm_wr;
  logic [3:0] hm_data;
  logic [4:0] mec_bar;
  logic       hmove_busy;
  logic       hmove_blank;

  tia_hmove_controller dut (
    .clk          (clk),
    .reset        (reset),
    .hmove_strobe (hmove_strobe),
    .hmclr        (hmclr),
    .hm_wr        (hm_wr),
    .hm_data      (hm_data),
    .mec_bar      (mec_bar),
    .hmove_busy   (hmove_busy),
    .hmove_blank  (hmove_blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] mec;
    logic       busy;
    logic       blank;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state.
  logic [3:0] m_hm [0:4];
  bit         m_active = 1'b0;
  int         m_start = 0;
  int         m_npulse [0:4];
  int         edge_n = 0;

  // Apply one edge worth of inputs and predict the cycle after that edge.
  task automatic drive(input bit rst, input bit stb, input bit clr,
                       input logic [4:0] wr, input logic [3:0] data);
    exp_t e;
    int   c;
    reset        = rst;
    hmove_strobe = stb;
    hmclr        = clr;
    hm_wr        = wr;
    hm_data      = data;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_hm[i] = 4'd0;
      m_active = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (clr) m_hm[i] = 4'd0;
        else if (wr[i]) m_hm[i] = data;
      end
      if (stb) begin
        m_active = 1'b1;
        m_start  = edge_n;
        for (int i = 0; i < 5; i++) m_npulse[i] = int'(m_hm[i] ^ 4'b1000);
      end
    end
    e.mec   = 5'b11111;
    e.busy  = 1'b0;
    e.blank = 1'b0;
    e.cyc   = edge_n + 1;
    c = edge_n + 1 - m_start;
    if (m_active && c >= 1 && c <= 64) begin
      e.busy = 1'b1;
`ifdef TIA_HMOVE_BLANK_EN
      if (c <= 8) e.blank = 1'b1;
`endif
      for (int i = 0; i < 5; i++)
        if (((c - 1) % 4 == 0) && ((c - 1) / 4 < m_npulse[i])) e.mec[i] = 1'b0;
    end
    if (m_active && c >= 64) m_active = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 5'b0, 4'h0);
  endtask

  // Monitor: outputs are presented every cycle; compare one entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (mec_bar !== e.mec || hmove_busy !== e.busy || hmove_blank !== e.blank) begin
          miscompares++;
          $display("FAIL cycle%0d outputs: mec_bar=%b busy=%b blank=%b, required mec_bar=%b busy=%b blank=%b",
                   e.cyc, mec_bar, hmove_busy, hmove_blank, e.mec, e.busy, e.blank);
        end
      end
    end
  end

  initial begin
    int wait_budget;
    reset = 1'b1; hmove_strobe = 1'b0; hmclr = 1'b0; hm_wr = 5'b0; hm_data = 4'h0;
    for (int i = 0; i < 5; i++) begin m_hm[i] = 4'd0; m_npulse[i] = 0; end

    // Reset state.
    drive(1'b1, 1'b0, 1'b0, 5'b0, 4'h0);
    drive(1'b1, 1'b1, 1'b1, 5'b11111, 4'hF);
    $display("vec reset: reset state checked");

    // All motion values zero: 8 pulses each, busy 64 cycles.
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(70);
    $display("vec zero: strobe with hm=0 for all objects");

    // M0=7 (15 pulses), M1=8 (none).
    drive(1'b0, 1'b0, 1'b0, 5'b00100, 4'h7);
    drive(1'b0, 1'b0, 1'b0, 5'b01000, 4'h8);
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(70);
    $display("vec m0m1: hm[M0]=7 hm[M1]=8 strobe");

    // Clear beats a simultaneous write.
    drive(1'b0, 1'b0, 1'b1, 5'b00100, 4'h7);
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(70);
    $display("vec hmclr: clear with simultaneous M0 write");

    // Restrobe at N+20.
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(19);
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(90);
    $display("vec restrobe: second strobe at N+20");

    // Reset mid-sequence at N+10, after loading non-zero values.
    drive(1'b0, 1'b0, 1'b0, 5'b00001, 4'h3);
    drive(1'b0, 1'b0, 1'b0, 5'b10000, 4'hC);
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(9);
    drive(1'b1, 1'b0, 1'b0, 5'b0, 4'h0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 5'b0, 4'h0);
    idle(70);
    $display("vec midreset: reset at N+10 then fresh strobe");

    // Randomized episodes: writes only while idle, random restrobes/resets.
    for (int ep = 0; ep < 40; ep++) begin
      int nwr;
      int len;
      nwr = $urandom_range(0, 5);
      for (int k = 0; k < nwr; k++)
        drive(1'b0, 1'b0, ($urandom_range(0, 9) == 0),
              5'b00001 << $urandom_range(0, 4), 4'($urandom_range(0, 15)));
      drive(1'b0, 1'b1, 1'b0, 5'b00001 << $urandom_range(0, 4), 4'($urandom_range(0, 15)));
      len = $urandom_range(10, 80);
      for (int k = 0; k < len; k++) begin
        int r;
        r = $urandom_range(0, 99);
        drive((r == 0), (r == 1), 1'b0, 5'b0, 4'h0);
      end
      while (m_active) idle(1);
      idle(1);
      $display("vec random%0d: episode with %0d writes, %0d cycles", ep, nwr, len);
    end

    wait_budget = 0;
    while (exp_q.size() > 0 && wait_budget < 100) begin
      @(posedge clk);
      wait_budget++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
